// File: rtl/pixel_unpacker.sv
// Pops DATA_SIZE-bit words from a show-ahead FIFO and emits PIX_SIZE-bit pixels under internal raster timing.
// Build option: define PIXEL_UNPACK_MSB_FIRST_EN to emit the most significant slice of each word first.
module pixel_unpacker #(
    parameter int DATA_SIZE = 32,
    parameter int PIX_SIZE  = 8,
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 160,
    parameter int V_ACTIVE  = 480,
    parameter int V_BLANK   = 45
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_r_ack,
    output logic [PIX_SIZE-1:0]  pixel,
    output logic                 line_valid,
    output logic                 frame_valid,
    output logic                 underflow
);
    localparam int          PPW      = DATA_SIZE / PIX_SIZE;
    localparam int          IDX_W    = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_BLANK - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPW - 1);

    typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_e;

    state_e               state_q;
    logic [15:0]          h_q, v_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_SIZE-1:0] word_q;
    logic [PIX_SIZE-1:0]  pixel_q;
    logic                 line_valid_q, frame_valid_q, underflow_q;

    // Pixel slices in emission order; slice 0 always leaves first.
    logic [PPW-1:0][PIX_SIZE-1:0] fifo_sl, word_sl;
    for (genvar k = 0; k < PPW; k++) begin : g_slice
`ifdef PIXEL_UNPACK_MSB_FIRST_EN
        assign fifo_sl[k] = fifo_data[DATA_SIZE-1-k*PIX_SIZE -: PIX_SIZE];
        assign word_sl[k] = word_q[DATA_SIZE-1-k*PIX_SIZE -: PIX_SIZE];
`else
        assign fifo_sl[k] = fifo_data[k*PIX_SIZE +: PIX_SIZE];
        assign word_sl[k] = word_q[k*PIX_SIZE +: PIX_SIZE];
`endif
    end

    logic                h_last, v_last, h_act, v_act, act, fetch;
    logic [PIX_SIZE-1:0] pixel_d;
    logic [IDX_W-1:0]    idx_d;

    always_comb begin
        h_last  = (h_q == H_LAST);
        v_last  = (v_q == V_LAST);
        h_act   = (h_q < H_ACT);
        v_act   = (v_q < V_ACT);
        act     = (state_q == RUN) && h_act && v_act;
        fetch   = act && (idx_q == '0);
        // The FIFO is only looked at on the first pixel of each word.
        fifo_r_ack = fetch && !fifo_empty;
        pixel_d = '0;
        if (fetch)
            pixel_d = fifo_empty ? '0 : fifo_sl[0];
        else if (act)
            pixel_d = word_sl[idx_q];
        idx_d = '0;
        if (act)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            idx_q         <= '0;
            word_q        <= '0;
            pixel_q       <= '0;
            line_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            pixel_q       <= pixel_d;
            line_valid_q  <= act;
            frame_valid_q <= (state_q == RUN) && v_act;
            case (state_q)
                IDLE: begin
                    h_q   <= '0;
                    v_q   <= '0;
                    idx_q <= '0;
                    if (en && !fifo_empty) begin
                        state_q     <= RUN;
                        underflow_q <= 1'b0;
                    end
                end
                RUN: begin
                    idx_q <= idx_d;
                    if (fetch) begin
                        // A missing word is replaced by zeros; the raster never waits.
                        word_q <= fifo_empty ? '0 : fifo_data;
                        if (fifo_empty)
                            underflow_q <= 1'b1;
                    end
                    if (h_last) begin
                        h_q <= '0;
                        if (v_last) begin
                            v_q <= '0;
                            if (!en)
                                state_q <= IDLE;
                        end else begin
                            v_q <= v_q + 16'd1;
                        end
                    end else begin
                        h_q <= h_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel       = pixel_q;
    assign line_valid  = line_valid_q;
    assign frame_valid = frame_valid_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker on a small 12x3 raster (8x2 active) with a queue-backed show-ahead FIFO.
module tb_pixel_unpacker;
    localparam int HT = 12;
    localparam int FRAME = 36;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        en = 1'b0;
    logic [31:0] fifo_data = 32'hDEADBEEF;
    logic        fifo_empty = 1'b1;
    logic        fifo_r_ack;
    logic [7:0]  pixel;
    logic        line_valid, frame_valid, underflow;

    pixel_unpacker #(
        .DATA_SIZE(32), .PIX_SIZE(8), .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(2), .V_BLANK(1)
    ) dut (
        .clk(clk), .nRST(nRST), .en(en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_r_ack(fifo_r_ack), .pixel(pixel), .line_valid(line_valid),
        .frame_valid(frame_valid), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] pix;
        logic       lv;
        logic       fv;
        logic       uf;
    } row_t;

    row_t        tbl [FRAME];
    logic [31:0] q [$];
    logic        ack_r = 1'b0;
    int          n_ack = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Present the FIFO head and sample the resulting combinational ack.
    task automatic drive();
        fifo_empty = (q.size() == 0);
        fifo_data  = fifo_empty ? 32'hDEADBEEF : q[0];
        #1;
        ack_r = fifo_r_ack;
        total++;
        if (ack_r && fifo_empty) begin
            bad++;
            $display("FAIL ack_on_empty: got ack=1 want 0 at %0t", $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (ack_r) begin
            if (q.size() > 0) void'(q.pop_front());
            n_ack++;
        end
        drive();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        en   = 1'b0;
        q.delete();
        drive();
        cyc();
        cyc();
        nRST  = 1'b1;
        n_ack = 0;
        drive();
    endtask

    // Test pattern words hold bytes 01..10 in ascending order from the LSB.
    function automatic logic [7:0] pos_pix(input int p);
        int w, k;
        w = p / 4;
        k = p % 4;
`ifdef PIXEL_UNPACK_MSB_FIRST_EN
        return 8'(4 * w + (3 - k) + 1);
`else
        return 8'(4 * w + k + 1);
`endif
    endfunction

    task automatic fill(input int en_off_row, input int word_base, input int words_avail);
        int h, v, p, uf_row;
        uf_row = ((4 * words_avail) / 8) * HT + (4 * words_avail) % 8;
        for (int r = 0; r < FRAME; r++) begin
            h = r % HT;
            v = r / HT;
            p = v * 8 + h;
            tbl[r].en  = (r < en_off_row);
            tbl[r].lv  = (h < 8) && (v < 2);
            tbl[r].fv  = (v < 2);
            tbl[r].pix = (tbl[r].lv && (p / 4) < words_avail) ? pos_pix(p + 4 * word_base) : 8'h00;
            tbl[r].uf  = (words_avail < 4) && (r >= uf_row);
        end
    endtask

    task automatic run_table(input string name, input int n);
        for (int r = 0; r < n; r++) begin
            en = tbl[r].en;
            drive();
            cyc();
            chk($sformatf("%s r%0d pixel", name, r), 32'(pixel), 32'(tbl[r].pix));
            chk($sformatf("%s r%0d line_valid", name, r), 32'(line_valid), 32'(tbl[r].lv));
            chk($sformatf("%s r%0d frame_valid", name, r), 32'(frame_valid), 32'(tbl[r].fv));
            chk($sformatf("%s r%0d underflow", name, r), 32'(underflow), 32'(tbl[r].uf));
        end
    endtask

    task automatic load4();
        q.push_back(32'h04030201);
        q.push_back(32'h08070605);
        q.push_back(32'h0C0B0A09);
        q.push_back(32'h100F0E0D);
    endtask

    // With en low after the frame, a waiting word must not be popped.
    task automatic check_idle(input string name);
        int a0;
        en = 1'b0;
        q.push_back(32'h55555555);
        drive();
        a0 = n_ack;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("%s idle%0d lv/fv/pix", name, i),
                {22'd0, line_valid, frame_valid, pixel}, 32'd0);
        end
        chk($sformatf("%s idle acks", name), 32'(n_ack), 32'(a0));
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst pixel", 32'(pixel), 32'd0);
        chk("rst line_valid", 32'(line_valid), 32'd0);
        chk("rst frame_valid", 32'(frame_valid), 32'd0);
        chk("rst underflow", 32'(underflow), 32'd0);
        chk("rst ack", 32'(ack_r), 32'd0);

        // Full frame, en dropped during vertical blanking
        load4();
        en = 1'b1;
        drive();
        cyc();
        fill(30, 0, 4);
        run_table("t1", FRAME);
        chk("t1 acks", 32'(n_ack), 32'd4);
        chk("t1 fifo drained", 32'(q.size()), 32'd0);
        check_idle("t1");

        // Only three words: fourth word reads as zeros, underflow sticks
        do_reset();
        q.push_back(32'h04030201);
        q.push_back(32'h08070605);
        q.push_back(32'h0C0B0A09);
        en = 1'b1;
        drive();
        cyc();
        fill(30, 0, 3);
        run_table("t2", FRAME);
        chk("t2 acks", 32'(n_ack), 32'd3);
        chk("t2 underflow sticky", 32'(underflow), 32'd1);
        check_idle("t2");
        chk("t2 underflow still set", 32'(underflow), 32'd1);

        // en dropped at line 1, h=3: frame still completes
        do_reset();
        load4();
        en = 1'b1;
        drive();
        cyc();
        fill(15, 0, 4);
        run_table("t3", FRAME);
        chk("t3 acks", 32'(n_ack), 32'd4);
        check_idle("t3");

        // Reset at line 0, h=5, then restart from the current FIFO head
        do_reset();
        load4();
        en = 1'b1;
        drive();
        cyc();
        fill(FRAME, 0, 4);
        run_table("t4a", 5);
        nRST = 1'b0;
        drive();
        cyc();
        chk("t4 rst pixel", 32'(pixel), 32'd0);
        chk("t4 rst lv/fv/uf", {29'd0, line_valid, frame_valid, underflow}, 32'd0);
        chk("t4 rst ack", 32'(ack_r), 32'd0);
        chk("t4 fifo left", 32'(q.size()), 32'd2);
        nRST = 1'b1;
        drive();
        cyc();
        fill(FRAME, 2, 2);
        run_table("t4b", 8);

        // en high on an empty FIFO holds IDLE until a word arrives
        do_reset();
        en = 1'b1;
        drive();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t5 wait%0d lv/ack", i), {30'd0, line_valid, ack_r}, 32'd0);
        end
        chk("t5 no acks", 32'(n_ack), 32'd0);
        q.push_back(32'h44332211);
        drive();
        chk("t5 ack before run", 32'(ack_r), 32'd0);
        cyc();
        chk("t5 ack first run cycle", 32'(ack_r), 32'd1);
        cyc();
`ifdef PIXEL_UNPACK_MSB_FIRST_EN
        chk("t5 first pixel", 32'(pixel), 32'h44);
`else
        chk("t5 first pixel", 32'(pixel), 32'h11);
`endif
        chk("t5 line_valid", 32'(line_valid), 32'd1);
        chk("t5 acks", 32'(n_ack), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
